mac_col_sequencer: RTL and testbench
====================================

// Module: mac_col_sequencer
// PURPOSE
//  Drives one mac_unit_16_Vert_2_module through a DATA_WIDTH-column bit-serial dot product; sits directly upstream of it.
//  Accepts one encoded weight-column word per column over valid/ready and issues registered MAC controls.
//  Inserts the prime, clear and flush cycles the MAC's 2-stage psum pipeline needs.
//  Captures the final MAC result into a 1-deep valid/ready output buffer.
// PARAMETERS
//  DATA_WIDTH     8                       activation/weight bits; also the number of columns per tile
//  VEC_LENGTH     16                      activations per MAC
//  MUX_SEL_WIDTH  $clog2(VEC_LENGTH)+1    hamming_sel width; act_sel width is MUX_SEL_WIDTH-1
//  RES_WIDTH      DATA_WIDTH+14           MAC result width
// PORTS
//  clk              in   1                     clock
//  reset            in   1                     asynchronous, active-high
//  cfg_valid        in   1                     column word valid
//  cfg_ready        out  1                     column word accepted; asserted only in RUN
//  cfg_act_sel      in   [VEC_LENGTH/2][MUX_SEL_WIDTH-1]  per-adder activation selects
//  cfg_hamming_sel  in   MUX_SEL_WIDTH         hamming activation select
//  cfg_hamming_sign in   1                     negate hamming activation
//  cfg_mul_const    in   3                     sum_act multiplier constant
//  cfg_is_shift_mul in   1                     shift constant product by 3
//  cfg_skip_zero    in   [2]                   per-half skip-zero flags
//  mac_en, mac_clear, mac_act_sel, mac_hamming_sel, mac_hamming_sign, mac_mul_const, mac_is_shift_mul,
//  mac_is_skip_zero, mac_column_idx[3], mac_is_msb   out   registered MAC controls; widths match the cfg_* ports
//  mac_result       in   RES_WIDTH             MAC accumulator output
//  res_valid        out  1                     result buffer holds a tile result
//  res_ready        in   1                     downstream accepts the result
//  res_data         out  RES_WIDTH             captured tile result
// BEHAVIOUR
//  Bubble controls (zero contribution):
//   - act_sel = ACT_ZERO_SEL (8, the tied-zero mux input); hamming_sel = HAM_ZERO_SEL (16)
//   - skip_zero = 2'b11, mul_const = 0, sign = 0, is_shift_mul = 0
//  Reset:
//   - state = IDLE, primed = 0, col_cnt = 0, res_valid = 0, res_data = 0
//   - mac_en = 0, mac_clear = 0, mac_column_idx = 0, mac_is_msb = 0, all other mac_* at bubble values
//  Output timing: all mac_* are registered; a value issued by the state in cycle c is visible to the MAC in c+1.
//  FSM:
//   - IDLE: cfg_valid & !res_valid -> (primed ? CLEAR : PRIME)
//   - PRIME: issue bubble with mac_en=1 (flushes the MAC tmp regs); primed <= 1; -> CLEAR
//   - CLEAR: issue mac_clear=1, mac_en=0; -> RUN
//   - RUN: cfg_ready=1
//       - on handshake: issue the word with mac_en=1, mac_column_idx=col_cnt, mac_is_msb=(col_cnt==DATA_WIDTH-1); col_cnt++
//       - without handshake: mac_en=0 and the other controls hold
//       - after the handshake with col_cnt==DATA_WIDTH-1: col_cnt <= 0; -> FLUSH
//   - FLUSH: issue bubble with mac_en=1 (last tmp enters result; tmp becomes 0); -> WAIT
//   - WAIT: mac_en=0; -> CAPTURE
//   - CAPTURE: res_data <= mac_result, res_valid <= 1; -> IDLE
//  Latency: 8th handshake in cycle t -> res_valid first high in t+4.
//  Output buffer: res_valid clears on res_valid & res_ready.
//   - IDLE does not start a tile while res_valid=1 (backpressure); cfg_ready stays 0.
//   - Release and start are not simultaneous: res_ready at cycle c allows the IDLE exit in c+1.
//  Boundaries:
//   - cfg_valid dropping mid-tile stalls RUN indefinitely with MAC state frozen.
//   - Column index wraps only through FLUSH; a 9th word is never accepted in the same tile.
//   - Async reset mid-tile aborts it: the partial MAC result is discarded, and primed=0 forces PRIME on the next tile.
//  Arithmetic: none on data; col_cnt is $clog2(DATA_WIDTH) bits.
// CONFIGURATION
//  SEQ_PERF_CNT_EN defined:
//   - adds outputs perf_stall_cnt[31:0] (RUN cycles with cfg_valid=0) and perf_tile_cnt[31:0] (CAPTURE count)
//   - both saturate at all-ones and clear on reset
//  SEQ_PERF_CNT_EN undefined: the ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package bitsim_seq_pkg:
//   - seq_state_t enum (IDLE, PRIME, CLEAR, RUN, FLUSH, WAIT, CAPTURE)
//   - col_word_t packed struct of the cfg_* fields
//   - ACT_ZERO_SEL and HAM_ZERO_SEL constants; BUBBLE_WORD constant
//  Natural sub-module: mac_col_ctrl_reg (col_word_t register with load/bubble/hold select); the FSM stays in the top.
// TESTING
//  1. After reset, 8 back-to-back words (mul_const=k for column k) -> PRIME, CLEAR, 8 en cycles with column_idx 0..7,
//     is_msb only at 7, FLUSH bubble; res_valid at 8th handshake+4.
//  2. Second tile with res_ready=1 -> no PRIME; CLEAR directly; same trace; res_data equals mac_result sampled in CAPTURE.
//  3. cfg_valid low 3 cycles after word 4 -> mac_en=0 and controls held for 3 cycles; the tile then completes
//     (perf_stall_cnt=3 with SEQ_PERF_CNT_EN).
//  4. res_ready=0 with the next tile pending -> cfg_ready stays 0, FSM holds IDLE;
//     res_ready=1 -> CLEAR one cycle later.
//  5. Async reset asserted during word 5 -> all outputs at reset values immediately; the next tile issues PRIME.
//  6. Bench MAC model with act all 1, sum_act fixed, alternating skip_zero -> res_data matches the golden dot product
//     for signed weight -1 (0xFF) and 127.

Source files
------------

// File: rtl/bitsim_seq_pkg.sv
// Package bitsim_seq_pkg
// Shared types and constants for the MAC column sequencer slice:
//   - tile geometry (DATA_WIDTH columns, VEC_LENGTH activations) and the widths derived from it
//   - seq_state_t : sequencer FSM states
//   - col_word_t  : one encoded weight-column control word (the cfg_*/mac_* field set)
//   - ctrl_sel_t  : next-value select for the registered control word
//   - ACT_ZERO_SEL / HAM_ZERO_SEL : mux inputs tied to zero inside the MAC
//   - BUBBLE_WORD : a control word that contributes nothing to the accumulator
package bitsim_seq_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int VEC_LENGTH    = 16;
    localparam int MUX_SEL_WIDTH = $clog2(VEC_LENGTH) + 1;
    localparam int ACT_SEL_WIDTH = MUX_SEL_WIDTH - 1;
    localparam int NUM_ADDERS    = VEC_LENGTH / 2;
    localparam int RES_WIDTH     = DATA_WIDTH + 14;
    localparam int COL_WIDTH     = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRIME   = 3'd1,
        CLEAR   = 3'd2,
        RUN     = 3'd3,
        FLUSH   = 3'd4,
        WAIT    = 3'd5,
        CAPTURE = 3'd6
    } seq_state_t;

    typedef struct packed {
        logic [NUM_ADDERS-1:0][ACT_SEL_WIDTH-1:0] act_sel;
        logic [MUX_SEL_WIDTH-1:0]                 hamming_sel;
        logic                                     hamming_sign;
        logic [2:0]                               mul_const;
        logic                                     is_shift_mul;
        logic [1:0]                               skip_zero;
    } col_word_t;

    typedef enum logic [1:0] {
        CTRL_HOLD   = 2'd0,
        CTRL_LOAD   = 2'd1,
        CTRL_BUBBLE = 2'd2
    } ctrl_sel_t;

    // Mux inputs one past the last real activation are wired to zero in the MAC.
    localparam logic [ACT_SEL_WIDTH-1:0] ACT_ZERO_SEL = ACT_SEL_WIDTH'(NUM_ADDERS);
    localparam logic [MUX_SEL_WIDTH-1:0] HAM_ZERO_SEL = MUX_SEL_WIDTH'(VEC_LENGTH);

    localparam col_word_t BUBBLE_WORD = '{
        act_sel:      {NUM_ADDERS{ACT_ZERO_SEL}},
        hamming_sel:  HAM_ZERO_SEL,
        hamming_sign: 1'b0,
        mul_const:    3'd0,
        is_shift_mul: 1'b0,
        skip_zero:    2'b11
    };

endpackage

// File: rtl/mac_col_ctrl_reg.sv
// Module mac_col_ctrl_reg
// Output register for the MAC column control word. Each cycle it either loads
// the incoming column word, loads the zero-contribution bubble, or holds.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (resets to BUBBLE_WORD)
//   sel        : CTRL_LOAD / CTRL_BUBBLE / CTRL_HOLD
//   word_in    : column word to load
//   word_out   : registered control word presented to the MAC
module mac_col_ctrl_reg
    import bitsim_seq_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  ctrl_sel_t sel,
    input  col_word_t word_in,
    output col_word_t word_out
);

    col_word_t word_d;
    col_word_t word_q;

    always_comb begin
        word_d = word_q;
        case (sel)
            CTRL_LOAD:   word_d = word_in;
            CTRL_BUBBLE: word_d = BUBBLE_WORD;
            default:     word_d = word_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= BUBBLE_WORD;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_out = word_q;

endmodule

// File: rtl/mac_col_sequencer.sv
// Module mac_col_sequencer
// Sequences one bit-serial MAC through a DATA_WIDTH-column dot product. Column
// words arrive over cfg_valid/cfg_ready; the sequencer adds the prime, clear and
// flush cycles that the MAC's two-stage psum pipeline needs, then captures the
// accumulator into a one-deep res_valid/res_ready buffer.
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   cfg_valid / cfg_ready    : column word handshake (ready only in RUN)
//   cfg_*                    : column word fields
//   mac_*                    : registered MAC controls (visible the cycle after issue)
//   mac_result               : MAC accumulator output
//   res_valid/res_ready/res_data : captured tile result
// Configuration macro SEQ_PERF_CNT_EN adds perf_stall_cnt (RUN cycles without
// cfg_valid) and perf_tile_cnt (captured tiles), both saturating.
module mac_col_sequencer
    import bitsim_seq_pkg::*;
(
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     cfg_valid,
    output logic                                     cfg_ready,
    input  logic [NUM_ADDERS-1:0][ACT_SEL_WIDTH-1:0] cfg_act_sel,
    input  logic [MUX_SEL_WIDTH-1:0]                 cfg_hamming_sel,
    input  logic                                     cfg_hamming_sign,
    input  logic [2:0]                               cfg_mul_const,
    input  logic                                     cfg_is_shift_mul,
    input  logic [1:0]                               cfg_skip_zero,
    output logic                                     mac_en,
    output logic                                     mac_clear,
    output logic [NUM_ADDERS-1:0][ACT_SEL_WIDTH-1:0] mac_act_sel,
    output logic [MUX_SEL_WIDTH-1:0]                 mac_hamming_sel,
    output logic                                     mac_hamming_sign,
    output logic [2:0]                               mac_mul_const,
    output logic                                     mac_is_shift_mul,
    output logic [1:0]                               mac_is_skip_zero,
    output logic [COL_WIDTH-1:0]                     mac_column_idx,
    output logic                                     mac_is_msb,
    input  logic [RES_WIDTH-1:0]                     mac_result,
    output logic                                     res_valid,
    input  logic                                     res_ready,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0]                              perf_stall_cnt,
    output logic [31:0]                              perf_tile_cnt,
`endif
    output logic [RES_WIDTH-1:0]                     res_data
);

    localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(DATA_WIDTH - 1);

    seq_state_t             state_q, state_d;
    logic                   primed_q, primed_d;
    logic [COL_WIDTH-1:0]   col_cnt_q, col_cnt_d;
    logic                   mac_en_q, mac_en_d;
    logic                   mac_clear_q, mac_clear_d;
    logic [COL_WIDTH-1:0]   col_idx_q, col_idx_d;
    logic                   is_msb_q, is_msb_d;
    logic                   res_valid_q, res_valid_d;
    logic [RES_WIDTH-1:0]   res_data_q, res_data_d;
    ctrl_sel_t              ctrl_sel;
    col_word_t              cfg_word;
    col_word_t              mac_word;
    logic                   cfg_hs;

    assign cfg_word = '{
        act_sel:      cfg_act_sel,
        hamming_sel:  cfg_hamming_sel,
        hamming_sign: cfg_hamming_sign,
        mul_const:    cfg_mul_const,
        is_shift_mul: cfg_is_shift_mul,
        skip_zero:    cfg_skip_zero
    };

    assign cfg_ready = (state_q == RUN);
    assign cfg_hs    = cfg_valid && cfg_ready;

    // Next-state and control issue. Every mac_* value decided here reaches the
    // MAC one cycle later. A tile cannot start while the previous result is
    // still unclaimed; the release and the start are therefore a cycle apart.
    always_comb begin
        state_d     = state_q;
        primed_d    = primed_q;
        col_cnt_d   = col_cnt_q;
        mac_en_d    = 1'b0;
        mac_clear_d = 1'b0;
        col_idx_d   = col_idx_q;
        is_msb_d    = is_msb_q;
        ctrl_sel    = CTRL_HOLD;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cfg_valid && !res_valid_q) begin
                    state_d = primed_q ? CLEAR : PRIME;
                end
            end
            PRIME: begin
                // Clocking a bubble through empties the MAC's tmp stage,
                // which holds garbage after reset.
                mac_en_d  = 1'b1;
                ctrl_sel  = CTRL_BUBBLE;
                col_idx_d = '0;
                is_msb_d  = 1'b0;
                primed_d  = 1'b1;
                state_d   = CLEAR;
            end
            CLEAR: begin
                mac_clear_d = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                if (cfg_hs) begin
                    mac_en_d  = 1'b1;
                    ctrl_sel  = CTRL_LOAD;
                    col_idx_d = col_cnt_q;
                    is_msb_d  = (col_cnt_q == COL_LAST);
                    if (col_cnt_q == COL_LAST) begin
                        col_cnt_d = '0;
                        state_d   = FLUSH;
                    end else begin
                        col_cnt_d = col_cnt_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                // Pushes the last column's tmp into the accumulator and leaves
                // tmp at zero, so the next tile needs no PRIME.
                mac_en_d  = 1'b1;
                ctrl_sel  = CTRL_BUBBLE;
                col_idx_d = '0;
                is_msb_d  = 1'b0;
                state_d   = WAIT;
            end
            WAIT: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                res_data_d  = mac_result;
                res_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            primed_q    <= 1'b0;
            col_cnt_q   <= '0;
            mac_en_q    <= 1'b0;
            mac_clear_q <= 1'b0;
            col_idx_q   <= '0;
            is_msb_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            primed_q    <= primed_d;
            col_cnt_q   <= col_cnt_d;
            mac_en_q    <= mac_en_d;
            mac_clear_q <= mac_clear_d;
            col_idx_q   <= col_idx_d;
            is_msb_q    <= is_msb_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    mac_col_ctrl_reg u_ctrl_reg (
        .clk      (clk),
        .reset    (reset),
        .sel      (ctrl_sel),
        .word_in  (cfg_word),
        .word_out (mac_word)
    );

    assign mac_en           = mac_en_q;
    assign mac_clear        = mac_clear_q;
    assign mac_act_sel      = mac_word.act_sel;
    assign mac_hamming_sel  = mac_word.hamming_sel;
    assign mac_hamming_sign = mac_word.hamming_sign;
    assign mac_mul_const    = mac_word.mul_const;
    assign mac_is_shift_mul = mac_word.is_shift_mul;
    assign mac_is_skip_zero = mac_word.skip_zero;
    assign mac_column_idx   = col_idx_q;
    assign mac_is_msb       = is_msb_q;
    assign res_valid        = res_valid_q;
    assign res_data         = res_data_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] tile_cnt_q, tile_cnt_d;

    // Saturating counters: a stall is a RUN cycle with no word offered.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        tile_cnt_d  = tile_cnt_q;
        if ((state_q == RUN) && !cfg_valid && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if ((state_q == CAPTURE) && (tile_cnt_q != '1)) begin
            tile_cnt_d = tile_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            tile_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            tile_cnt_q  <= tile_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_tile_cnt  = tile_cnt_q;
`else
    // Performance counters are not built.
`endif

endmodule

// File: tb/tb_mac_col_sequencer.sv
// Testbench tb_mac_col_sequencer
// Drives column words into mac_col_sequencer, stands in for the MAC with a
// small bit-serial accumulator, and compares every output each cycle against a
// tile-script model (a tile is a list of steps: optional prime, clear, eight
// accepted columns, flush, wait, capture). Literal expectations pin the model:
// reset values, enable/clear/msb counts per tile, result latency and golden
// dot products.
// Build with +define+SEQ_PERF_CNT_EN to also check the perf counters.
module tb_mac_col_sequencer;
    import bitsim_seq_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic                                     cfg_valid = 1'b0;
    logic                                     cfg_ready;
    logic [NUM_ADDERS-1:0][ACT_SEL_WIDTH-1:0] cfg_act_sel = '0;
    logic [MUX_SEL_WIDTH-1:0]                 cfg_hamming_sel = '0;
    logic                                     cfg_hamming_sign = 1'b0;
    logic [2:0]                               cfg_mul_const = '0;
    logic                                     cfg_is_shift_mul = 1'b0;
    logic [1:0]                               cfg_skip_zero = '0;
    logic                                     mac_en;
    logic                                     mac_clear;
    logic [NUM_ADDERS-1:0][ACT_SEL_WIDTH-1:0] mac_act_sel;
    logic [MUX_SEL_WIDTH-1:0]                 mac_hamming_sel;
    logic                                     mac_hamming_sign;
    logic [2:0]                               mac_mul_const;
    logic                                     mac_is_shift_mul;
    logic [1:0]                               mac_is_skip_zero;
    logic [COL_WIDTH-1:0]                     mac_column_idx;
    logic                                     mac_is_msb;
    logic [RES_WIDTH-1:0]                     mac_result;
    logic                                     res_valid;
    logic                                     res_ready = 1'b1;
    logic [RES_WIDTH-1:0]                     res_data;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]                              perf_stall_cnt;
    logic [31:0]                              perf_tile_cnt;
`endif

    always #5 clk = ~clk;

    mac_col_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_act_sel      (cfg_act_sel),
        .cfg_hamming_sel  (cfg_hamming_sel),
        .cfg_hamming_sign (cfg_hamming_sign),
        .cfg_mul_const    (cfg_mul_const),
        .cfg_is_shift_mul (cfg_is_shift_mul),
        .cfg_skip_zero    (cfg_skip_zero),
        .mac_en           (mac_en),
        .mac_clear        (mac_clear),
        .mac_act_sel      (mac_act_sel),
        .mac_hamming_sel  (mac_hamming_sel),
        .mac_hamming_sign (mac_hamming_sign),
        .mac_mul_const    (mac_mul_const),
        .mac_is_shift_mul (mac_is_shift_mul),
        .mac_is_skip_zero (mac_is_skip_zero),
        .mac_column_idx   (mac_column_idx),
        .mac_is_msb       (mac_is_msb),
        .mac_result       (mac_result),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
`ifdef SEQ_PERF_CNT_EN
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_tile_cnt    (perf_tile_cnt),
`endif
        .res_data         (res_data)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    col_word_t cfg_word_tb;
    col_word_t dut_word;
    assign cfg_word_tb = {cfg_act_sel, cfg_hamming_sel, cfg_hamming_sign, cfg_mul_const,
                          cfg_is_shift_mul, cfg_skip_zero};
    assign dut_word    = {mac_act_sel, mac_hamming_sel, mac_hamming_sign, mac_mul_const,
                          mac_is_shift_mul, mac_is_skip_zero};

    // Stand-in MAC: all activations are 1, so an un-skipped half of eight
    // adders contributes mul_const*8. The contribution is weighted by 2^column
    // and negated on the MSB column; it waits one enable in tmp before reaching
    // the accumulator, as in the real two-stage pipeline.
    logic signed [RES_WIDTH-1:0] acc = '0;
    logic signed [RES_WIDTH-1:0] tmp = '0;
    assign mac_result = acc;

    function automatic logic signed [RES_WIDTH-1:0] col_contrib(input logic [2:0] mc, input logic [1:0] sz,
                                                               input logic [COL_WIDTH-1:0] idx, input logic msb);
        int halves;
        int v;
        halves = (sz[0] ? 0 : 1) + (sz[1] ? 0 : 1);
        v = int'(mc) * halves * NUM_ADDERS;
        v = v << idx;
        if (msb) v = -v;
        return RES_WIDTH'(v);
    endfunction

    initial forever begin
        @(posedge clk);
        if (mac_clear) begin
            acc <= '0;
        end else if (mac_en) begin
            acc <= acc + tmp;
            tmp <= col_contrib(mac_mul_const, mac_is_skip_zero, mac_column_idx, mac_is_msb);
        end
    end

    // Tile-script model.
    localparam byte STEP_PRIME = 8'd1;
    localparam byte STEP_CLEAR = 8'd2;
    localparam byte STEP_COLS  = 8'd3;
    localparam byte STEP_FLUSH = 8'd4;
    localparam byte STEP_WAIT  = 8'd5;
    localparam byte STEP_CAP   = 8'd6;

    byte                  script[$];
    bit                   m_primed    = 1'b0;
    int                   words_taken = 0;
    bit                   m_old_rv;
    logic                 exp_en      = 1'b0;
    logic                 exp_clear   = 1'b0;
    col_word_t            exp_word    = BUBBLE_WORD;
    logic [COL_WIDTH-1:0] exp_idx     = '0;
    logic                 exp_msb     = 1'b0;
    logic                 exp_rv      = 1'b0;
    logic [RES_WIDTH-1:0] exp_rd      = '0;
    int                   exp_stall   = 0;
    int                   exp_tiles   = 0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            script.delete();
            m_primed    = 1'b0;
            words_taken = 0;
            exp_en      = 1'b0;
            exp_clear   = 1'b0;
            exp_word    = BUBBLE_WORD;
            exp_idx     = '0;
            exp_msb     = 1'b0;
            exp_rv      = 1'b0;
            exp_rd      = '0;
            exp_stall   = 0;
            exp_tiles   = 0;
        end else begin
            m_old_rv  = exp_rv;
            exp_en    = 1'b0;
            exp_clear = 1'b0;
            if (script.size() == 0) begin
                if (cfg_valid && !m_old_rv) begin
                    if (!m_primed) script.push_back(STEP_PRIME);
                    script.push_back(STEP_CLEAR);
                    script.push_back(STEP_COLS);
                    script.push_back(STEP_FLUSH);
                    script.push_back(STEP_WAIT);
                    script.push_back(STEP_CAP);
                end
            end else begin
                case (script[0])
                    STEP_PRIME: begin
                        exp_en = 1'b1; exp_word = BUBBLE_WORD; exp_idx = '0; exp_msb = 1'b0;
                        m_primed = 1'b1;
                        void'(script.pop_front());
                    end
                    STEP_CLEAR: begin
                        exp_clear = 1'b1;
                        void'(script.pop_front());
                    end
                    STEP_COLS: begin
                        if (cfg_valid) begin
                            exp_en   = 1'b1;
                            exp_word = cfg_word_tb;
                            exp_idx  = COL_WIDTH'(words_taken);
                            exp_msb  = (words_taken == DATA_WIDTH - 1);
                            words_taken++;
                            if (words_taken == DATA_WIDTH) begin
                                words_taken = 0;
                                void'(script.pop_front());
                            end
                        end else begin
                            exp_stall++;
                        end
                    end
                    STEP_FLUSH: begin
                        exp_en = 1'b1; exp_word = BUBBLE_WORD; exp_idx = '0; exp_msb = 1'b0;
                        void'(script.pop_front());
                    end
                    STEP_WAIT: begin
                        void'(script.pop_front());
                    end
                    default: begin
                        exp_rd = mac_result;
                        exp_rv = 1'b1;
                        exp_tiles++;
                        void'(script.pop_front());
                    end
                endcase
            end
            if (m_old_rv && res_ready) exp_rv = 1'b0;
        end
    end

    // Per-cycle comparison against the model.
    bit cmp_on = 1'b0;
    initial forever begin
        @(negedge clk);
        if (cmp_on && !reset) begin
            checkOutput("cfg_ready", cfg_ready, (script.size() > 0 && script[0] == STEP_COLS));
            checkOutput("mac_en", mac_en, exp_en);
            checkOutput("mac_clear", mac_clear, exp_clear);
            checkOutput("mac_word", 64'(dut_word), 64'(exp_word));
            checkOutput("mac_column_idx", mac_column_idx, exp_idx);
            checkOutput("mac_is_msb", mac_is_msb, exp_msb);
            checkOutput("res_valid", res_valid, exp_rv);
            checkOutput("res_data", res_data, exp_rd);
`ifdef SEQ_PERF_CNT_EN
            checkOutput("perf_stall_cnt", perf_stall_cnt, exp_stall);
            checkOutput("perf_tile_cnt", perf_tile_cnt, exp_tiles);
`endif
        end
    end

    // Event counters for the literal checks.
    int cyc = 0;
    int en_cnt = 0, clear_cnt = 0, msb_cnt = 0, ready_cnt = 0;
    int last_hs_cyc = 0, rv_cyc = 0;
    bit prev_rv = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (reset) begin
            prev_rv = 1'b0;
        end else begin
            if (cfg_valid && cfg_ready) last_hs_cyc = cyc;
            if (res_valid && !prev_rv) rv_cyc = cyc;
            prev_rv = res_valid;
            if (mac_en) en_cnt++;
            if (mac_clear) clear_cnt++;
            if (mac_en && mac_is_msb) msb_cnt++;
            if (cfg_ready) ready_cnt++;
        end
    end

    task automatic reset_counters();
        en_cnt = 0; clear_cnt = 0; msb_cnt = 0; ready_cnt = 0;
    endtask

    // mode 0: mul_const = column index, no skipping.
    // mode 1: weight bit k selects mul_const 2 or 0, with alternating half skips,
    //         so column k is worth 16 * bit k in the stand-in MAC.
    function automatic col_word_t make_word(input int mode, input int weight, input int k);
        col_word_t w;
        for (int lane = 0; lane < NUM_ADDERS; lane++) begin
            w.act_sel[lane] = ACT_SEL_WIDTH'((k + lane) % NUM_ADDERS);
        end
        w.hamming_sel  = MUX_SEL_WIDTH'(k);
        w.hamming_sign = k[0];
        w.is_shift_mul = k[1];
        if (mode == 0) begin
            w.mul_const = 3'(k);
            w.skip_zero = 2'b00;
        end else begin
            w.mul_const = weight[k] ? 3'd2 : 3'd0;
            w.skip_zero = k[0] ? 2'b10 : 2'b01;
        end
        return w;
    endfunction

    task automatic drive_word(input col_word_t w);
        cfg_act_sel      = w.act_sel;
        cfg_hamming_sel  = w.hamming_sel;
        cfg_hamming_sign = w.hamming_sign;
        cfg_mul_const    = w.mul_const;
        cfg_is_shift_mul = w.is_shift_mul;
        cfg_skip_zero    = w.skip_zero;
    endtask

    // Sends one tile. Called just after a rising edge. stall_after: column after
    // which cfg_valid drops for 3 cycles (-1 none). abort_at: column during
    // which reset is pulsed (-1 none). Without abort, waits for res_valid.
    task automatic applyStimulus(input int mode, input int weight, input int stall_after, input int abort_at);
        bit ok;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            drive_word(make_word(mode, weight, k));
            cfg_valid = 1'b1;
            if (k == abort_at) begin
                #2;
                reset = 1'b1;
                #1;
                checkOutput("abort_mac_en", mac_en, 0);
                checkOutput("abort_cfg_ready", cfg_ready, 0);
                checkOutput("abort_col_idx", mac_column_idx, 0);
                checkOutput("abort_ham_sel", mac_hamming_sel, 16);
                checkOutput("abort_skip_zero", mac_is_skip_zero, 3);
                checkOutput("abort_res_valid", res_valid, 0);
                @(negedge clk);
                @(negedge clk);
                reset     = 1'b0;
                cfg_valid = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            ok = 1'b0;
            for (int i = 0; i < 100 && !ok; i++) begin
                @(negedge clk);
                ok = cfg_ready;
                @(posedge clk);
                #1;
            end
            cfg_valid = 1'b0;
            if (!ok) begin
                checkOutput("handshake_timeout", 0, 1);
                return;
            end
            if (k == stall_after) begin
                repeat (3) @(posedge clk);
                #1;
            end
        end
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = res_valid;
        end
        @(posedge clk);
        #1;
        if (!ok) checkOutput("res_valid_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] start");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        cmp_on = 1'b1;

        checkOutput("rst_mac_en", mac_en, 0);
        checkOutput("rst_mac_clear", mac_clear, 0);
        checkOutput("rst_act_sel", mac_act_sel, 64'h8888_8888);
        checkOutput("rst_ham_sel", mac_hamming_sel, 16);
        checkOutput("rst_skip_zero", mac_is_skip_zero, 3);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_res_data", res_data, 0);
        checkOutput("rst_cfg_ready", cfg_ready, 0);

        // Tile 1: first tile after reset, includes PRIME.
        reset_counters();
        applyStimulus(0, 0, -1, -1);
        checkOutput("t1_en_cnt", en_cnt, 10);
        checkOutput("t1_clear_cnt", clear_cnt, 1);
        checkOutput("t1_msb_cnt", msb_cnt, 1);
        checkOutput("t1_latency", rv_cyc - last_hs_cyc, 4);
        checkOutput("t1_res", longint'($signed(res_data)), -4064);

        // Tile 2: already primed.
        reset_counters();
        applyStimulus(0, 0, -1, -1);
        checkOutput("t2_en_cnt", en_cnt, 9);
        checkOutput("t2_clear_cnt", clear_cnt, 1);
        checkOutput("t2_latency", rv_cyc - last_hs_cyc, 4);
        checkOutput("t2_res", longint'($signed(res_data)), -4064);

        // Tile 3: 3-cycle gap after column 4.
        reset_counters();
        applyStimulus(0, 0, 3, -1);
        checkOutput("t3_en_cnt", en_cnt, 9);
        checkOutput("t3_res", longint'($signed(res_data)), -4064);
`ifdef SEQ_PERF_CNT_EN
        checkOutput("t3_perf_stall", perf_stall_cnt, 3);
        checkOutput("t3_perf_tiles", perf_tile_cnt, 3);
`endif

        // Tile 4: result left unclaimed blocks the next tile.
        res_ready = 1'b0;
        reset_counters();
        applyStimulus(0, 0, -1, -1);
        checkOutput("t4_en_cnt", en_cnt, 9);
        drive_word(make_word(0, 0, 0));
        cfg_valid = 1'b1;
        ready_cnt = 0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("t4_ready_blocked", ready_cnt, 0);
        checkOutput("t4_res_held", res_valid, 1);
        res_ready = 1'b1;
        reset_counters();
        applyStimulus(0, 0, -1, -1);
        checkOutput("t4b_en_cnt", en_cnt, 9);
        checkOutput("t4b_clear_cnt", clear_cnt, 1);

        // Tile 5: reset in the middle of column 5, then a signed -1 weight tile.
        applyStimulus(0, 0, -1, 4);
        reset_counters();
        applyStimulus(1, -1, -1, -1);
        checkOutput("t5_en_cnt_primed", en_cnt, 10);
        checkOutput("t5_res_neg1", longint'($signed(res_data)), -16);

        // Tile 6: weight 127.
        reset_counters();
        applyStimulus(1, 127, -1, -1);
        checkOutput("t6_en_cnt", en_cnt, 9);
        checkOutput("t6_res_127", longint'($signed(res_data)), 2032);

        repeat (4) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
